mp_carry_chain: RTL and testbench
=================================

# mp_carry_chain

Downstream carry-propagation stage for the 64×64+64+64 multiply-add pipeline in cp_core. Consumes the 128-bit products of one schoolbook row, one limb per beat (p_i = a_i·b + t_i, with the d input tied to zero). Adds the running inter-limb carry to each product and emits the 64-bit result limbs in order, followed by one final carry limb. Output is buffered in a small FIFO so the big-integer sequencer can apply backpressure.

## Interface
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)
- IDX_W, 8, width of the limb index counter
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  product beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_p  in  128  product from the multiply-add stage
- in_first  in  1  beat is limb 0 of a row
- in_last  in  1  beat is the last product limb of a row
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes the head this cycle
- out_limb  out  64  result limb
- out_idx  out  IDX_W  limb index within the row, 0-based
- out_last  out  1  limb is the final carry limb of the row
- ovf  out  1  sticky: carry out of bit 128 seen on a flushed row
- err  out  1  sticky: in_first received while a row was open

## Operation
- Beat accepted when in_valid && in_ready.
- sum[128:0] = in_p + C, where C is the 65-bit carry register. C is treated as 0 when in_first is set or state is IDLE.
- On accept: push {sum[63:0], idx, 0} to the FIFO; C <= sum[128:64]; idx <= idx+1 (idx treated as 0 for a first beat or an IDLE start).
- States:
  - IDLE: any accepted beat opens a row. Next state is RUN, or FLUSH if in_last.
  - RUN: accepted beat with in_last → FLUSH.
  - FLUSH: when the FIFO is not full, push {C[63:0], idx, out_last=1}; set ovf if C[64]; clear C and idx; → IDLE. Stays in FLUSH while the FIFO is full.
- in_first && in_last on one beat: single-limb row. One data limb, then the flush limb.
- in_first in RUN: open row discarded without a flush limb; err set; new row starts (C=0, idx=0).
- idx wraps modulo 2^IDX_W, with no error.
- ovf and err clear only on reset.
- Reset mid-row: FIFO emptied, C/idx cleared, state IDLE, ovf/err cleared. Partial row lost.

## Timing
- Reset values: in_ready=1, out_valid=0, out_limb=0, out_idx=0, out_last=0, ovf=0, err=0.
- in_ready = (state != FLUSH) && !fifo_full, from registered state only. No combinational path from in_valid or out_ready.
- Data limb visible at out_* the cycle after acceptance if the FIFO was empty.
- Flush limb is pushed in the cycle after the in_last beat, or later if the FIFO is full. in_ready is low for that cycle, so consecutive rows incur one bubble.
- Full sustained throughput: one beat per cycle while out_ready=1.
- Simultaneous push and pop: both occur; occupancy unchanged. No push occurs while full, because in_ready is already low.
- out_* hold stable while out_valid && !out_ready.

## Test plan
- Carry across limbs: in_p=2^64+5 (first), then in_p=7 (last), out_ready=1.
  - Expect limbs 5 (idx0), 8 (idx1), 0 (idx2, out_last).
  - ovf=0.
- Max values: in_p=2^128−1 (first), then 2^128−1 (last).
  - Expect limb 0xFFFF_FFFF_FFFF_FFFF, then 0xFFFF_FFFF_FFFF_FFFE.
  - Flush limb 0; ovf=1.
- Backpressure: out_ready=0, five beats offered.
  - in_ready drops after 4 accepts.
  - After out_ready=1, all limbs and the flush limb drain in order with none lost.
  - Head is stable while stalled.
- Single-limb row: one beat with first&&last, in_p=0xAB<<64 | 0x12.
  - Expect limb 0x12 (idx0), then 0xAB (idx1, out_last).
- Restart error: first, 2^64 (carry 1), then a new first with in_p=3.
  - Expect limb 0, then 3 (idx0, carry not added).
  - No flush limb for the abandoned row; err=1.
- Mid-row reset: assert rst_n low after two beats.
  - All outputs return to reset values; FIFO empty.
  - Next row starts at idx0 with C=0.

Source files
------------

// File: rtl/mp_carry_chain.sv
// Carry-propagation stage for one schoolbook row: adds the inter-limb carry to each
// 128-bit product, emits 64-bit result limbs plus a final carry limb through an output FIFO.
module mp_carry_chain #(
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_p,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_limb,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             ovf,
    output logic             err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W = 64 + IDX_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [64:0]      c_q, c_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;

    logic             fifo_full;
    logic             accept;
    logic             fresh;
    logic [64:0]      c_eff;
    logic [IDX_W-1:0] idx_eff;
    logic [128:0]     sum;
    logic             flush_push;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] push_data;

    assign fifo_full = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign in_ready  = (state_q != S_FLUSH) && !fifo_full;
    assign accept    = in_valid && in_ready;
    assign pop       = (count_q != '0) && out_ready;

    // A first beat, or any beat arriving while idle, starts from a clean carry and index.
    assign fresh   = in_first || (state_q == S_IDLE);
    assign c_eff   = fresh ? 65'd0 : c_q;
    assign idx_eff = fresh ? '0 : idx_q;
    assign sum     = {1'b0, in_p} + {64'd0, c_eff};

    assign flush_push = (state_q == S_FLUSH) && !fifo_full;
    assign push       = accept || flush_push;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        c_d       = c_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        push_data = '0;
        if (accept) begin
            push_data = {sum[63:0], idx_eff, 1'b0};
            c_d       = sum[128:64];
            idx_d     = idx_eff + IDX_W'(1);
            state_d   = in_last ? S_FLUSH : S_RUN;
            if (in_first && (state_q == S_RUN)) begin
                err_d = 1'b1;
            end
        end else if (flush_push) begin
            push_data = {c_q[63:0], idx_q, 1'b1};
            ovf_d     = ovf_q | c_q[64];
            c_d       = '0;
            idx_d     = '0;
            state_d   = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the storage array is reset as well, because out_limb/out_idx/out_last must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_valid                      = (count_q != '0);
    assign {out_limb, out_idx, out_last}  = mem_q[rd_ptr_q];
    assign ovf                            = ovf_q;
    assign err                            = err_q;

endmodule

// File: tb/tb_mp_carry_chain.sv
// Self-checking bench for mp_carry_chain: directed row scenarios plus randomized rows,
// compared against a big-integer limb model and a log of every popped output limb.
`timescale 1ns/1ps
module tb_mp_carry_chain;

    typedef struct packed {
        logic [63:0] limb;
        logic [7:0]  idx;
        logic        last;
    } ent_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_p;
    logic         in_first;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_limb;
    logic [7:0]   out_idx;
    logic         out_last;
    logic         ovf;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    ent_t exp_q[$];
    ent_t pop_log[$];

    logic        m_open;
    logic [64:0] m_c;
    logic [7:0]  m_idx;
    logic        m_ovf;
    logic        m_err;

    ent_t held;
    bit   held_v;

    mp_carry_chain #(.FIFO_DEPTH(4), .IDX_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p      (in_p),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_limb  (out_limb),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .ovf       (ovf),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Row-level reference: the row value is the sum of products weighted by 2^(64*k);
    // each output limb is that running big integer's next 64-bit digit.
    task automatic model_reset();
        exp_q.delete();
        m_open = 1'b0;
        m_c    = '0;
        m_idx  = '0;
        m_ovf  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_accept(input logic [127:0] p, input logic f, input logic l);
        logic [128:0] s;
        ent_t e;
        if (f && m_open) m_err = 1'b1;
        if (f || !m_open) begin
            m_c   = '0;
            m_idx = '0;
        end
        s      = {1'b0, p} + {64'd0, m_c};
        e.limb = s[63:0];
        e.idx  = m_idx;
        e.last = 1'b0;
        exp_q.push_back(e);
        m_c    = s[128:64];
        m_idx  = m_idx + 8'd1;
        m_open = 1'b1;
        if (l) begin
            e.limb = m_c[63:0];
            e.idx  = m_idx;
            e.last = 1'b1;
            exp_q.push_back(e);
            if (m_c[64]) m_ovf = 1'b1;
            m_open = 1'b0;
        end
    endtask

    // Output monitor: samples 1ns after the falling edge, scoring every pop and stall.
    always @(negedge clk) begin
        ent_t act;
        #1;
        act = {out_limb, out_idx, out_last};
        if (rst_n) begin
            if (held_v && out_valid) check("hold_stable", 128'(act), 128'(held));
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    check("pop_data", 128'(act), 128'(exp_q[0]));
                    void'(exp_q.pop_front());
                end else begin
                    check("pop_unexpected", 128'(exp_q.size()), 128'(1));
                end
                pop_log.push_back(act);
            end
            held_v = out_valid && !out_ready;
            held   = act;
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic send(input logic [127:0] p, input logic f, input logic l, input bit rnd);
        bit ok;
        ok       = 1'b0;
        in_p     = p;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            if (in_ready) begin
                model_accept(p, f, l);
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        check("send_accept", 128'(ok), 128'(1));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("drain_empty", 128'(exp_q.size()), 128'(0));
        check("drain_out_valid", 128'(out_valid), 128'(0));
    endtask

    task automatic check_log(input int k, input logic [63:0] limb, input logic [7:0] idx, input logic last);
        ent_t e;
        e.limb = limb;
        e.idx  = idx;
        e.last = last;
        if (pop_log.size() > k) check($sformatf("log%0d", k), 128'(pop_log[k]), 128'(e));
        else check("log_missing", 128'(pop_log.size()), 128'(k + 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_out_limb"}, 128'(out_limb), 128'(0));
        check({tag, "_out_idx"}, 128'(out_idx), 128'(0));
        check({tag, "_out_last"}, 128'(out_last), 128'(0));
        check({tag, "_ovf"}, 128'(ovf), 128'(0));
        check({tag, "_err"}, 128'(err), 128'(0));
    endtask

    initial begin
        logic [127:0] p;
        int len;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_p      = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        held_v    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Carry across limbs.
        pop_log.delete();
        out_ready = 1'b1;
        send((128'd1 << 64) + 128'd5, 1'b1, 1'b0, 1'b0);
        send(128'd7, 1'b0, 1'b1, 1'b0);
        drain();
        check_log(0, 64'd5, 8'd0, 1'b0);
        check_log(1, 64'd8, 8'd1, 1'b0);
        check_log(2, 64'd0, 8'd2, 1'b1);
        check("carry_ovf", 128'(ovf), 128'(0));

        // Maximum products: carry escapes bit 128 on the flush.
        pop_log.delete();
        send({128{1'b1}}, 1'b1, 1'b0, 1'b0);
        send({128{1'b1}}, 1'b0, 1'b1, 1'b0);
        drain();
        check_log(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0, 1'b0);
        check_log(1, 64'hFFFF_FFFF_FFFF_FFFE, 8'd1, 1'b0);
        check_log(2, 64'd0, 8'd2, 1'b1);
        check("max_ovf", 128'(ovf), 128'(1));

        // Single-limb row.
        pop_log.delete();
        send((128'hAB << 64) | 128'h12, 1'b1, 1'b1, 1'b0);
        drain();
        check_log(0, 64'h12, 8'd0, 1'b0);
        check_log(1, 64'hAB, 8'd1, 1'b1);

        // Restart while a row is open: old row abandoned, no flush limb for it.
        pop_log.delete();
        send(128'd1 << 64, 1'b1, 1'b0, 1'b0);
        send(128'd3, 1'b1, 1'b1, 1'b0);
        drain();
        check_log(0, 64'd0, 8'd0, 1'b0);
        check_log(1, 64'd3, 8'd0, 1'b0);
        check_log(2, 64'd0, 8'd1, 1'b1);
        check("restart_len", 128'(pop_log.size()), 128'(3));
        check("restart_err", 128'(err), 128'(1));

        // Backpressure: four beats fill the FIFO, the fifth waits.
        pop_log.delete();
        out_ready = 1'b0;
        send(128'd1, 1'b1, 1'b0, 1'b0);
        for (int k = 2; k <= 4; k++) send(128'(k), 1'b0, 1'b0, 1'b0);
        check("bp_in_ready_full", 128'(in_ready), 128'(0));
        check("bp_out_valid", 128'(out_valid), 128'(1));
        repeat (3) @(negedge clk);
        check("bp_in_ready_stall", 128'(in_ready), 128'(0));
        check("bp_head", 128'({out_limb, out_idx, out_last}), 128'(exp_q[0]));
        out_ready = 1'b1;
        send(128'd5, 1'b0, 1'b1, 1'b0);
        drain();
        for (int k = 0; k < 5; k++) check_log(k, 64'(k + 1), 8'(k), 1'b0);
        check_log(5, 64'd0, 8'd5, 1'b1);

        // Reset in the middle of a row.
        out_ready = 1'b0;
        send((128'd1 << 64) + 128'd1, 1'b1, 1'b0, 1'b0);
        send(128'd2, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pop_log.delete();
        out_ready = 1'b1;
        send(128'd9, 1'b0, 1'b1, 1'b0);
        drain();
        check_log(0, 64'd9, 8'd0, 1'b0);
        check_log(1, 64'd0, 8'd1, 1'b1);

        // Randomized rows with random backpressure and occasional restarts.
        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 5) == 0) p = {128{1'b1}};
                else p = {$urandom(), $urandom(), $urandom(), $urandom()};
                send(p, (b == 0) || ($urandom_range(0, 15) == 0), b == len - 1, 1'b1);
            end
        end
        drain();

        // Long row: the limb index wraps modulo 256.
        for (int b = 0; b < 260; b++) begin
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(p, b == 0, b == 259, 1'b1);
        end
        drain();
        check("final_ovf", 128'(ovf), 128'(m_ovf));
        check("final_err", 128'(err), 128'(m_err));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
